// File: rtl/toy_mem_arb.sv
// Two-port round-robin arbiter and sequencer for the toy CPU memory bus.
// Serialises CPU and I/O requests, drives the strobes and captures read data.
module toy_mem_arb #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CPU_REQ,
    input  logic       CPU_RORW,
    input  logic [7:0] CPU_ADDR,
    input  logic [7:0] CPU_WDATA,
    output logic       CPU_GNT,
    output logic       CPU_ACK,
    input  logic       IO_REQ,
    input  logic       IO_RORW,
    input  logic [7:0] IO_ADDR,
    input  logic [7:0] IO_WDATA,
    output logic       IO_GNT,
    output logic       IO_ACK,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic [7:0] ADDR,
    output logic [7:0] D_OUT,
    input  logic [7:0] D_IN,
    output logic       MEM_EN,
    output logic       RORW
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic       r_win;
    logic       r_rorw;
    logic [7:0] r_addr;
    logic [7:0] r_dout;
    logic [7:0] r_rdata;
    logic [1:0] r_cnt;

    logic       w_any;
    logic       w_pick_io;
    logic       w_last_wait;
    logic       w_sel_rorw;
    logic [7:0] w_sel_addr;
    logic [7:0] w_sel_wdata;
    logic       w_latch;

    // r_last/r_win: 1 = I/O requester, 0 = CPU
    assign w_any       = CPU_REQ | IO_REQ;
    assign w_pick_io   = IO_REQ & (~CPU_REQ | ~r_last);
    assign w_last_wait = (r_cnt == LAT_M1);
    assign w_latch     = (r_state == S_IDLE) & w_any;

    assign w_sel_rorw  = w_pick_io ? IO_RORW  : CPU_RORW;
    assign w_sel_addr  = w_pick_io ? IO_ADDR  : CPU_ADDR;
    assign w_sel_wdata = w_pick_io ? IO_WDATA : CPU_WDATA;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = r_rorw ? S_WAIT : S_DONE;
            S_WAIT:  if (w_last_wait) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_last  <= 1'b1;
            r_win   <= 1'b0;
            r_rorw  <= 1'b1;
            r_addr  <= 8'h00;
            r_dout  <= 8'h00;
            r_rdata <= 8'h00;
            r_cnt   <= 2'd0;
        end else begin
            if (w_latch) begin
                r_win  <= w_pick_io;
                r_rorw <= w_sel_rorw;
                r_addr <= w_sel_addr;
                if (!w_sel_rorw) r_dout <= w_sel_wdata;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= 2'd0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 2'd1;
            end
            // D_IN is only trusted on the edge that ends the final WAIT cycle
            if ((r_state == S_WAIT) && w_last_wait) r_rdata <= D_IN;
            if (r_state == S_DONE) r_last <= r_win;
        end
    end

    assign BUSY    = (r_state != S_IDLE);
    assign MEM_EN  = (r_state == S_ISSUE);
    assign CPU_GNT = BUSY & ~r_win;
    assign IO_GNT  = BUSY & r_win;
    assign CPU_ACK = (r_state == S_DONE) & ~r_win;
    assign IO_ACK  = (r_state == S_DONE) & r_win;
    assign ADDR    = r_addr;
    assign D_OUT   = r_dout;
    assign RORW    = r_rorw;
    assign RDATA   = r_rdata;

endmodule

// File: tb/tb_toy_mem_arb.sv
// Scoreboard bench for toy_mem_arb: directed cases plus random two-port traffic
// against a reference memory image and round-robin fairness rules.
module tb_toy_mem_arb;

    localparam int RD_LAT = 3;

    typedef struct packed {
        logic       rorw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       CPU_REQ = 1'b0;
    logic       CPU_RORW = 1'b0;
    logic [7:0] CPU_ADDR = 8'h00;
    logic [7:0] CPU_WDATA = 8'h00;
    logic       IO_REQ = 1'b0;
    logic       IO_RORW = 1'b0;
    logic [7:0] IO_ADDR = 8'h00;
    logic [7:0] IO_WDATA = 8'h00;
    logic [7:0] D_IN = 8'h00;
    logic       CPU_GNT, CPU_ACK, IO_GNT, IO_ACK;
    logic       BUSY, MEM_EN, RORW;
    logic [7:0] RDATA, ADDR, D_OUT;

    int errors = 0;
    int checks = 0;

    txn_t       exp_q[2][$];
    int         grant_log[$];
    logic [7:0] rmem[256] = '{default: 8'h00};
    logic [7:0] bmem[256] = '{default: 8'h00};
    logic [1:0] req_s = 2'b00;
    logic       rst_s = 1'b0;

    toy_mem_arb #(.RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_RORW(CPU_RORW),
        .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_GNT(CPU_GNT), .CPU_ACK(CPU_ACK),
        .IO_REQ(IO_REQ), .IO_RORW(IO_RORW),
        .IO_ADDR(IO_ADDR), .IO_WDATA(IO_WDATA),
        .IO_GNT(IO_GNT), .IO_ACK(IO_ACK),
        .RDATA(RDATA), .BUSY(BUSY), .ADDR(ADDR), .D_OUT(D_OUT),
        .D_IN(D_IN), .MEM_EN(MEM_EN), .RORW(RORW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_en"}, 32'(MEM_EN), 0);
        chk({tag, "_rorw"}, 32'(RORW), 1);
        chk({tag, "_addr"}, 32'(ADDR), 0);
        chk({tag, "_dout"}, 32'(D_OUT), 0);
        chk({tag, "_rdata"}, 32'(RDATA), 0);
        chk({tag, "_gnt"}, 32'({CPU_GNT, IO_GNT}), 0);
        chk({tag, "_ack"}, 32'({CPU_ACK, IO_ACK}), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
    endtask

    // Requests are driven just after a falling edge
    task automatic issue(input int p, input logic rw, input logic [7:0] a,
                         input logic [7:0] d);
        txn_t t;
        t.rorw = rw;
        t.addr = a;
        t.wdata = d;
        exp_q[p].push_back(t);
        if (p == 0) begin
            CPU_REQ = 1'b1; CPU_RORW = rw; CPU_ADDR = a; CPU_WDATA = d;
        end else begin
            IO_REQ = 1'b1; IO_RORW = rw; IO_ADDR = a; IO_WDATA = d;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) CPU_REQ = 1'b0;
        else IO_REQ = 1'b0;
    endtask

    task automatic wait_ack(input int p, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            cyc++;
            if ((p == 0) ? CPU_ACK : IO_ACK) begin
                checks++;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout port %0d: got no ACK in %0d cycles, expected ACK",
                 p, cyc);
    endtask

    task automatic txn(input int p, input logic rw, input logic [7:0] a,
                       input logic [7:0] d, output int cyc);
        @(negedge CLK);
        issue(p, rw, a, d);
        wait_ack(p, cyc);
        drop(p);
    endtask

    task automatic requester(input int p, input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            issue(p, 1'($urandom % 2), 8'($urandom_range(0, 15)), 8'($urandom));
            wait_ack(p, c);
        end
        drop(p);
    endtask

    task automatic rand_req(input int p, input int n);
        int c;
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                drop(p);
                repeat (gap) @(negedge CLK);
            end
            issue(p, 1'($urandom % 2), 8'($urandom_range(0, 15)), 8'($urandom));
            wait_ack(p, c);
        end
        drop(p);
    endtask

    // What the DUT sees on each rising edge
    initial forever begin
        @(posedge CLK);
        req_s = {CPU_REQ, IO_REQ};
        rst_s = RESET;
    end

    // Memory model: random D_IN except on the final WAIT cycle of a read
    initial begin : memmodel
        int rd_cnt;
        logic [7:0] rd_addr;
        rd_cnt = 0;
        rd_addr = 8'h00;
        forever begin
            @(negedge CLK);
            D_IN = 8'($urandom);
            if (!rst_s) begin
                rd_cnt = 0;
            end else begin
                if (rd_cnt != 0) begin
                    rd_cnt--;
                    if (rd_cnt == 0) D_IN = bmem[rd_addr];
                end
                if (MEM_EN && RORW) begin
                    rd_cnt = RD_LAT;
                    rd_addr = ADDR;
                end
                if (MEM_EN && !RORW) bmem[ADDR] = D_OUT;
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        bit         inflight;
        bit         last_ref;
        bit         prev_busy;
        int         cyc_since;
        int         cur_p;
        int         g;
        int         w;
        txn_t       cur;
        logic [7:0] rdata_ref;
        inflight = 0;
        last_ref = 1;
        prev_busy = 0;
        cyc_since = 0;
        cur_p = 0;
        cur = '0;
        rdata_ref = 8'h00;
        forever begin
            @(negedge CLK);
            if (!rst_s) begin
                inflight = 0;
                last_ref = 1;
                prev_busy = 0;
                rdata_ref = 8'h00;
                exp_q[0].delete();
                exp_q[1].delete();
            end else begin
                if (CPU_GNT && IO_GNT) chk("gnt_overlap", 32'({CPU_GNT, IO_GNT}), 32'h1);
                if (inflight) cyc_since++;
                if (MEM_EN) begin
                    if (inflight) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_mem_en: got MEM_EN at %0d, expected none", cyc_since);
                    end
                    chk("idle_gap", 32'(prev_busy), 0);
                    chk("one_gnt", 32'(CPU_GNT ^ IO_GNT), 1);
                    g = IO_GNT ? 1 : 0;
                    if (req_s == 2'b11) w = last_ref ? 0 : 1;
                    else w = req_s[1] ? 0 : 1;
                    chk("winner", 32'(g), 32'(w));
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_txn port %0d: got MEM_EN, expected no request", g);
                    end else begin
                        cur = exp_q[g].pop_front();
                        chk("bus_addr", 32'(ADDR), 32'(cur.addr));
                        chk("bus_rorw", 32'(RORW), 32'(cur.rorw));
                        if (!cur.rorw) chk("bus_dout", 32'(D_OUT), 32'(cur.wdata));
                    end
                    inflight = 1;
                    cyc_since = 0;
                    cur_p = g;
                end
                if (CPU_ACK || IO_ACK) begin
                    if (!inflight) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_ack: got ACK %0b%0b, expected none",
                                 CPU_ACK, IO_ACK);
                    end else begin
                        chk("ack_port", 32'({CPU_ACK, IO_ACK}), cur_p ? 32'h1 : 32'h2);
                        chk("ack_latency", 32'(cyc_since),
                            cur.rorw ? 32'(1 + RD_LAT) : 32'h1);
                        if (cur.rorw) rdata_ref = rmem[cur.addr];
                        else rmem[cur.addr] = cur.wdata;
                        chk("rdata", 32'(RDATA), 32'(rdata_ref));
                        last_ref = (cur_p == 1);
                        inflight = 0;
                        grant_log.push_back(cur_p);
                    end
                end
                prev_busy = BUSY;
            end
        end
    end

    initial begin : main
        int c;
        int base;
        repeat (2) @(negedge CLK);
        chk_reset("rst");
        RESET = 1'b1;
        @(negedge CLK);

        // CPU write, REQ dropped during ISSUE
        issue(0, 1'b0, 8'h04, 8'hAA);
        @(negedge CLK);
        chk("w_mem_en", 32'(MEM_EN), 1);
        chk("w_rorw", 32'(RORW), 0);
        chk("w_addr", 32'(ADDR), 32'h04);
        chk("w_dout", 32'(D_OUT), 32'hAA);
        chk("w_io_gnt", 32'(IO_GNT), 0);
        drop(0);
        @(negedge CLK);
        chk("w_ack", 32'(CPU_ACK), 1);
        chk("w_io_gnt2", 32'(IO_GNT), 0);
        @(negedge CLK);
        chk("w_idle", 32'({BUSY, MEM_EN}), 0);
        @(negedge CLK);
        chk("w_no_reissue", 32'(MEM_EN), 0);

        txn(0, 1'b0, 8'h10, 8'hFF, c);
        chk("wr_lat", 32'(c), 2);
        txn(0, 1'b0, 8'h20, 8'hCC, c);
        txn(1, 1'b1, 8'h10, 8'h00, c);
        chk("rd_lat", 32'(c), 32'(2 + RD_LAT));
        chk("rd_data", 32'(RDATA), 32'hFF);
        txn(0, 1'b0, 8'h05, 8'h3C, c);
        chk("rdata_hold", 32'(RDATA), 32'hFF);
        txn(1, 1'b1, 8'h20, 8'h00, c);
        chk("rd3_lat", 32'(c), 5);
        chk("rd3_data", 32'(RDATA), 32'hCC);

        // Tie with continuous re-request
        base = grant_log.size();
        @(negedge CLK);
        fork
            requester(0, 2);
            requester(1, 2);
        join
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tie_order%0d", i),
                32'((grant_log.size() > base + i) ? grant_log[base + i] : 9),
                32'(i % 2));
        end

        // Reset in the middle of a CPU read
        @(negedge CLK);
        issue(0, 1'b1, 8'h10, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_busy", 32'(BUSY), 1);
        RESET = 1'b0;
        drop(0);
        @(negedge CLK);
        chk_reset("abort");
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_no_ack", 32'({CPU_ACK, BUSY}), 0);
        base = grant_log.size();
        fork
            requester(0, 1);
            requester(1, 1);
        join
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("post_rst_order%0d", i),
                32'((grant_log.size() > base + i) ? grant_log[base + i] : 9),
                32'(i));
        end

        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        base = grant_log.size();
        requester(1, 1);
        chk("io_alone",
            32'((grant_log.size() > base) ? grant_log[base] : 9), 1);

        @(negedge CLK);
        fork
            rand_req(0, 40);
            rand_req(1, 40);
        join
        repeat (3) @(negedge CLK);
        chk("leftover", 32'(exp_q[0].size() + exp_q[1].size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toy_mem_arb.md
# toy_mem_arb

Two-port memory arbiter and sequencer that shares the toy CPU's single 8-bit memory bus (ADDR, D_OUT, D_IN, MEM_EN, RORW) between the CPU core and an I/O/loader requester. Each requester issues one read or write at a time through a REQ/GNT/ACK handshake. The block serialises the requests with round-robin priority, drives the memory strobes and captures read data after a fixed latency. It sits between the toy_sch datapath and the memory model.

## Interface
- RD_LAT, 1, read latency: cycles from the MEM_EN cycle to the clock edge at which D_IN is valid; legal range 1..4.

- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-low reset (sampled on CLK rising edge)
- CPU_REQ  in  1  CPU transaction request; held high until CPU_ACK
- CPU_RORW  in  1  CPU direction: 1 = read, 0 = write
- CPU_ADDR  in  8  CPU address
- CPU_WDATA  in  8  CPU write data
- CPU_GNT  out  1  CPU owns the bus (ISSUE through DONE)
- CPU_ACK  out  1  one-cycle pulse: CPU transaction complete
- IO_REQ, IO_RORW, IO_ADDR, IO_WDATA  in  1/1/8/8  same meaning for I/O requester
- IO_GNT, IO_ACK  out  1/1  same meaning for I/O requester
- RDATA  out  8  last captured read data (shared by both requesters)
- BUSY  out  1  high whenever state is not IDLE
- ADDR  out  8  memory address
- D_OUT  out  8  memory write data
- D_IN  in  8  memory read data
- MEM_EN  out  1  memory strobe, high exactly one cycle per transaction
- RORW  out  1  memory direction: 1 = read, 0 = write

## Operation
- States: IDLE, ISSUE, WAIT, DONE; all outputs are registers or decoded from the registered state (glitch-free).
- IDLE: if any REQ is high, pick the winner, latch its RORW/ADDR/WDATA into internal registers and move to ISSUE. Otherwise stay.
- Arbitration: a single request wins outright. When both requests are high, the winner is the requester not served last. The LAST register holds the last-served requester; it resets to IO, so the CPU wins the first tie.
- ISSUE (1 cycle): MEM_EN=1. ADDR, D_OUT and RORW are driven from the latched values. The winner's GNT goes high. Write transactions go to DONE; read transactions go to WAIT.
- WAIT (RD_LAT cycles): MEM_EN=0 and ADDR/RORW are held. On the edge ending the last WAIT cycle, D_IN is captured into RDATA. The block then moves to DONE.
- DONE (1 cycle): the winner's ACK=1 and GNT stays high. LAST is updated to the winner on the exit edge. Next state is IDLE.
- ADDR, D_OUT and RORW keep their last values after the transaction. They change only when the next transaction is latched.
- D_OUT loads WDATA only for writes; for reads it holds its prior value.
- RDATA changes only on read capture. It holds through writes and idle periods.
- Dropping REQ after it has been latched does not abort the transaction; ACK still pulses.
- REQ still high in the IDLE cycle after DONE is treated as a new request. Requesters drop REQ at the edge where they see ACK=1.
- The non-winning requester's GNT and ACK stay 0 throughout. Its request stays pending and is served on the next IDLE.

## Timing
- Reset values (one edge with RESET=0): state=IDLE, MEM_EN=0, RORW=1, ADDR=0x00, D_OUT=0x00, RDATA=0x00, all GNT/ACK=0, BUSY=0, LAST=IO.
- RESET=0 in any state aborts the transaction. Outputs take reset values after that edge; no ACK is issued for the aborted transaction, and RDATA is not updated.
- Write, with REQ sampled in IDLE at cycle 0: cycle 1 ISSUE (MEM_EN=1), cycle 2 DONE (ACK=1), cycle 3 IDLE. Occupancy is 3 cycles.
- Read: cycle 1 ISSUE, cycles 2..1+RD_LAT WAIT, cycle 2+RD_LAT DONE with ACK=1 and RDATA already valid. Occupancy is 3+RD_LAT cycles.
- D_IN is sampled only at the final WAIT edge. D_IN values at all other times are ignored.
- Back-to-back: at least one IDLE cycle separates two transactions. Worst-case wait for a requester facing a continuously requesting peer is one peer transaction.

## Test plan
- Reset then CPU write: CPU_REQ=1, CPU_RORW=0, CPU_ADDR=0x04, CPU_WDATA=0xAA -> cycle 1 shows MEM_EN=1, RORW=0, ADDR=0x04, D_OUT=0xAA; cycle 2 shows CPU_ACK=1; IO_GNT stays 0.
- IO read, RD_LAT=1: IO_ADDR=0x10, D_IN=0xFF at the WAIT edge -> MEM_EN high exactly one cycle with RORW=1; in the DONE cycle IO_ACK=1 and RDATA=0xFF; RDATA still 0xFF after a later write.
- Simultaneous REQ from both requesters held continuously (with re-request after each ACK) -> order CPU, IO, CPU, IO; one IDLE cycle between grants; GNTs never overlap.
- RD_LAT=3 read: D_IN=0x11 in WAIT cycles 1–2, then 0xCC at the final WAIT edge -> RDATA=0xCC; ACK arrives in cycle 5 after the request.
- RESET low during WAIT of a CPU read -> next cycle all reset values, no CPU_ACK, RDATA=0x00. After release, a pending IO_REQ is served first only if CPU_REQ is low (LAST=IO, so the CPU wins a tie).
- REQ dropped in the ISSUE cycle of a write -> transaction completes and ACK still pulses; no second MEM_EN follows.
